// File: rtl/a2910_sequencer.sv
// a2910_sequencer: Am2910-style microprogram sequencer.
// Next-address mux (Y) is combinational; uPC, loop counter R and the
// return-address stack update on the rising clock edge.
module a2910_sequencer #(
  parameter int AW     = 12,
  parameter int SDEPTH = 5
) (
  input  logic          CLK,
  input  logic          RSTbar,
  input  logic [3:0]    I,
  input  logic          CCbar,
  input  logic          CCENbar,
  input  logic          RLDbar,
  input  logic          CI,
  input  logic          OEbar,
  input  logic [AW-1:0] D,
  output logic [AW-1:0] Y,
  output logic          PLbar,
  output logic          MAPbar,
  output logic          VECTbar,
  output logic          FULLbar
);

  localparam int SPW = $clog2(SDEPTH + 1);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(SDEPTH);

  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CJS  = 4'd1;
  localparam logic [3:0] OP_JMAP = 4'd2;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_JSRP = 4'd5;
  localparam logic [3:0] OP_CJV  = 4'd6;
  localparam logic [3:0] OP_JRP  = 4'd7;
  localparam logic [3:0] OP_RFCT = 4'd8;
  localparam logic [3:0] OP_RPCT = 4'd9;
  localparam logic [3:0] OP_CRTN = 4'd10;
  localparam logic [3:0] OP_CJPP = 4'd11;
  localparam logic [3:0] OP_LDCT = 4'd12;
  localparam logic [3:0] OP_LOOP = 4'd13;
  localparam logic [3:0] OP_CONT = 4'd14;
  localparam logic [3:0] OP_TWB  = 4'd15;

  logic [AW-1:0]              upc, r, y_int, tos;
  logic [SDEPTH-1:0][AW-1:0]  stk;
  logic [SPW-1:0]             sp, top_idx;
  logic                       pass, rz, full;
  logic                       push, pop, clr, ldr, dec;

  assign pass    = CCENbar | ~CCbar;
  assign rz      = (r == '0);
  assign full    = (sp == SP_FULL);
  assign top_idx = sp - SP_ONE;
  // An empty stack reads as address 0.
  assign tos     = (sp == '0) ? '0 : stk[top_idx];

  assign Y       = OEbar ? {AW{1'bz}} : y_int;
  assign MAPbar  = (I != OP_JMAP);
  assign VECTbar = (I != OP_CJV);
  assign PLbar   = (I == OP_JMAP) || (I == OP_CJV);
  assign FULLbar = ~full;

  // Opcode decode: next-address select plus stack/counter side effects.
  always_comb begin
    y_int = upc;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    ldr   = 1'b0;
    dec   = 1'b0;
    case (I)
      OP_JZ:   begin y_int = '0; clr = 1'b1; end
      OP_CJS:  if (pass) begin y_int = D; push = 1'b1; end
      OP_JMAP: y_int = D;
      OP_CJP:  if (pass) y_int = D;
      OP_PUSH: begin push = 1'b1; ldr = pass; end
      OP_JSRP: begin push = 1'b1; y_int = pass ? D : r; end
      OP_CJV:  if (pass) y_int = D;
      OP_JRP:  y_int = pass ? D : r;
      OP_RFCT: if (!rz) begin y_int = tos; dec = 1'b1; end
               else pop = 1'b1;
      OP_RPCT: if (!rz) begin y_int = D; dec = 1'b1; end
      OP_CRTN: if (pass) begin y_int = tos; pop = 1'b1; end
      OP_CJPP: if (pass) begin y_int = D; pop = 1'b1; end
      OP_LDCT: ldr = 1'b1;
      OP_LOOP: if (pass) pop = 1'b1;
               else y_int = tos;
      OP_CONT: ;
      OP_TWB:  if (!rz) begin
                 dec = 1'b1;
                 if (pass) pop = 1'b1;
                 else y_int = tos;
               end else begin
                 pop = 1'b1;
                 if (!pass) y_int = D;
               end
      default: ;
    endcase
  end

  // Microprogram counter: always the selected address plus carry-in.
  always_ff @(posedge CLK or negedge RSTbar) begin
    if (!RSTbar) upc <= '0;
    else         upc <= y_int + AW'(CI);
  end

  // Loop counter: external load wins over opcode load/decrement; never wraps below 0.
  always_ff @(posedge CLK or negedge RSTbar) begin
    if (!RSTbar)              r <= '0;
    else if (!RLDbar || ldr)  r <= D;
    else if (dec && !rz)      r <= r - AW'(1);
  end

  // Return stack: clear beats push/pop; push on full overwrites the top entry.
  always_ff @(posedge CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      sp  <= '0;
      stk <= '0;
    end else if (clr) begin
      sp  <= '0;
      stk <= '0;
    end else if (push) begin
      if (full) stk[SDEPTH-1] <= upc;
      else begin
        stk[sp] <= upc;
        sp      <= sp + SP_ONE;
      end
    end else if (pop && sp != '0) begin
      sp <= sp - SP_ONE;
    end
  end

endmodule

// File: tb/tb_a2910_sequencer.sv
// Bench for a2910_sequencer: directed scenarios plus random opcodes, all
// checked every cycle against a queue-based behavioural model.
module tb_a2910_sequencer;
  localparam int AW = 12, SDEPTH = 5;
  localparam int MASK = (1 << AW) - 1;
  localparam int JZ = 0, CJS = 1, JMAP = 2, CJP = 3, PUSH = 4, JSRP = 5, CJV = 6, JRP = 7;
  localparam int RFCT = 8, RPCT = 9, CRTN = 10, CJPP = 11, LDCT = 12, LOOP = 13, CONT = 14, TWB = 15;

  logic          CLK = 1'b0, RSTbar = 1'b0;
  logic [3:0]    I = 4'd14;
  logic          CCbar = 1'b1, CCENbar = 1'b1, RLDbar = 1'b1, CI = 1'b1, OEbar = 1'b0;
  logic [AW-1:0] D = '0;
  wire  [AW-1:0] Y;
  wire           PLbar, MAPbar, VECTbar, FULLbar;

  a2910_sequencer #(.AW(AW), .SDEPTH(SDEPTH)) dut (
    .CLK(CLK), .RSTbar(RSTbar), .I(I), .CCbar(CCbar), .CCENbar(CCENbar),
    .RLDbar(RLDbar), .CI(CI), .OEbar(OEbar), .D(D), .Y(Y),
    .PLbar(PLbar), .MAPbar(MAPbar), .VECTbar(VECTbar), .FULLbar(FULLbar));

  always #5 CLK = ~CLK;

  int m_upc = 0, m_r = 0;
  int m_stk[$];
  int checks = 0, errors = 0;
  bit done = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_tos();
    return (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
  endfunction

  // Opcode table from the instruction set: next address and side effects.
  task automatic model_eval(input int op, input int d, input bit pass,
                            output int y, output bit pu, output bit po,
                            output bit cl, output bit ld, output bit de);
    bit rz = (m_r == 0);
    y = m_upc; pu = 0; po = 0; cl = 0; ld = 0; de = 0;
    case (op)
      JZ:   begin y = 0; cl = 1; end
      CJS:  if (pass) begin y = d; pu = 1; end
      JMAP: y = d;
      CJP:  if (pass) y = d;
      PUSH: begin pu = 1; ld = pass; end
      JSRP: begin pu = 1; y = pass ? d : m_r; end
      CJV:  if (pass) y = d;
      JRP:  y = pass ? d : m_r;
      RFCT: if (!rz) begin y = m_tos(); de = 1; end else po = 1;
      RPCT: if (!rz) begin y = d; de = 1; end
      CRTN: if (pass) begin y = m_tos(); po = 1; end
      CJPP: if (pass) begin y = d; po = 1; end
      LDCT: ld = 1;
      LOOP: if (pass) po = 1; else y = m_tos();
      TWB:  begin
              po = rz || pass;
              de = !rz;
              if (!pass) y = rz ? d : m_tos();
            end
      default: ;
    endcase
  endtask

  // Per-cycle compare against the model, then advance the model one clock.
  task automatic checker_loop();
    int  y, op;
    bit  pu, po, cl, ld, de, pass;
    while (!done) begin
      @(negedge CLK or negedge RSTbar);
      if (!RSTbar) begin
        m_upc = 0; m_r = 0; m_stk.delete();
      end else begin
        op   = int'(I);
        pass = CCENbar || !CCbar;
        model_eval(op, int'(D), pass, y, pu, po, cl, ld, de);
        if (!OEbar) chk("y_model", int'(Y), y);
        chk("strobes_model", int'({PLbar, MAPbar, VECTbar}),
            int'({op == JMAP || op == CJV, op != JMAP, op != CJV}));
        chk("fullbar_model", int'(FULLbar), int'(m_stk.size() != SDEPTH));
        if (cl) m_stk.delete();
        else if (pu) begin
          if (m_stk.size() < SDEPTH) m_stk.push_back(m_upc);
          else m_stk[SDEPTH-1] = m_upc;
        end else if (po && m_stk.size() > 0) void'(m_stk.pop_back());
        if (!RLDbar || ld) m_r = int'(D);
        else if (de && m_r != 0) m_r = m_r - 1;
        m_upc = (y + int'(CI)) & MASK;
      end
    end
  endtask

  task automatic step(input int op, input int d, input bit cc = 1'b1, input bit ccen = 1'b1,
                      input bit rld = 1'b1, input bit ci = 1'b1, input bit oe = 1'b0);
    @(posedge CLK); #1;
    I = 4'(op); D = AW'(d); CCbar = cc; CCENbar = ccen; RLDbar = rld; CI = ci; OEbar = oe;
    #1;
  endtask

  task automatic directed();
    // reset held across clocks: state must stay at reset values
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_y", int'(Y), 0);
    chk("rst_fullbar", int'(FULLbar), 1);
    @(posedge CLK); #1; RSTbar = 1'b1; #1;
    chk("cont_y0", int'(Y), 0);
    for (int k = 1; k <= 3; k++) begin step(CONT, 0); chk("cont_seq", int'(Y), k); end
    step(CONT, 0); chk("cont_upc4", int'(Y), 4);

    // counted loop
    step(CJP, 'h0F); chk("jmp_0f", int'(Y), 'h0F);
    step(LDCT, 3);   chk("ldct_y", int'(Y), 'h10);
    step(PUSH, 3, 1'b1, 1'b0); chk("push_y", int'(Y), 'h11);
    for (int k = 3; k >= 1; k--) begin
      step(JRP, 0, 1'b1, 1'b0); chk("loop_r", int'(Y), k);
      step(RFCT, 0);            chk("rfct_tos", int'(Y), 'h11);
    end
    step(JRP, 0, 1'b1, 1'b0); chk("loop_r0", int'(Y), 0);
    step(RFCT, 0);            chk("rfct_exit", int'(Y), 1);
    step(CRTN, 0);            chk("loop_stack_empty", int'(Y), 0);

    // subroutine call/return
    step(CJP, 5);                          chk("jmp_05", int'(Y), 5);
    step(CJS, 'h200, 1'b0, 1'b0);          chk("cjs_y", int'(Y), 'h200);
    step(LOOP, 0, 1'b1, 1'b0);             chk("cjs_tos", int'(Y), 'h006);
    step(CRTN, 0);                         chk("crtn_y", int'(Y), 'h006);
    step(CRTN, 0);                         chk("crtn_empty", int'(Y), 0);
    step(CJS, 'h200, 1'b1, 1'b0);          chk("cjs_fail_y", int'(Y), 1);
    step(CRTN, 0);                         chk("cjs_fail_nopush", int'(Y), 0);

    // stack overflow / underflow
    step(CJP, 'h20); chk("jmp_20", int'(Y), 'h20);
    for (int k = 0; k < 6; k++) begin
      step(PUSH, 0, 1'b1, 1'b0);
      chk("push6_y", int'(Y), 'h21 + k);
      if (k == 4) chk("fullbar_4deep", int'(FULLbar), 1);
      if (k == 5) chk("fullbar_5deep", int'(FULLbar), 0);
    end
    step(CRTN, 0);
    chk("model_depth", m_stk.size(), 5);
    chk("model_top", m_tos(), 'h26);
    chk("pop_overwritten", int'(Y), 'h26);
    chk("fullbar_still", int'(FULLbar), 0);
    for (int k = 4; k >= 1; k--) begin
      step(CRTN, 0); chk("pop_seq", int'(Y), 'h20 + k);
      if (k == 4) chk("fullbar_after_pop", int'(FULLbar), 1);
    end
    step(CRTN, 0);             chk("pop_empty", int'(Y), 0);
    step(PUSH, 0, 1'b1, 1'b0); chk("push_after_under", int'(Y), 1);
    step(LOOP, 0, 1'b1, 1'b0); chk("tos_after_under", int'(Y), 1);
    step(CRTN, 0);             chk("crtn_after_under", int'(Y), 1);
    step(CRTN, 0);             chk("empty_again", int'(Y), 0);

    // strobes and output enable
    step(JMAP, 'h0AB);
    chk("jmap_y", int'(Y), 'h0AB);
    chk("jmap_strobes", int'({PLbar, MAPbar, VECTbar}), 'b101);
    step(CJV, 'h0CD);
    chk("cjv_y", int'(Y), 'h0CD);
    chk("cjv_strobes", int'({PLbar, MAPbar, VECTbar}), 'b110);
    step(CONT, 0);
    chk("cont_strobes", int'({PLbar, MAPbar, VECTbar}), 'b011);
    step(CONT, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("oe_float", int'((Y === {AW{1'bz}}) || (Y == '0)), 1);
    step(CONT, 0); chk("oe_state_kept", int'(Y), 'h0D0);
    step(JZ, 'h123); chk("jz_y", int'(Y), 0);

    // RLDbar overrides the RPCT decrement
    step(LDCT, 7);
    step(RPCT, 'h40, 1'b1, 1'b1, 1'b0); chk("rpct_rld_y", int'(Y), 'h40);
    step(JRP, 0, 1'b1, 1'b0);            chk("rld_override", int'(Y), 'h40);

    // asynchronous reset in the middle of a counted RPCT
    step(LDCT, 5);
    step(RPCT, 'h55); chk("rpct_y", int'(Y), 'h55);
    #1 RSTbar = 1'b0;
    #1 chk("async_rst_y", int'(Y), 0);
    chk("async_rst_fullbar", int'(FULLbar), 1);
    RSTbar = 1'b1;
    step(JRP, 0, 1'b1, 1'b0); chk("async_rst_r", int'(Y), 0);
  endtask

  task automatic random_phase();
    int op, d;
    bit cc, ccen, rld, ci, oe;
    for (int n = 0; n < 3000; n++) begin
      op   = int'($urandom_range(0, 15));
      d    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, MASK));
      cc   = ($urandom_range(0, 1) == 0);
      ccen = ($urandom_range(0, 3) == 0);
      rld  = ($urandom_range(0, 7) != 0);
      ci   = ($urandom_range(0, 7) != 0);
      oe   = ($urandom_range(0, 15) == 0);
      step(op, d, cc, ccen, rld, ci, oe);
      if ($urandom_range(0, 255) == 0) begin
        #1 RSTbar = 1'b0;
        #1 RSTbar = 1'b1;
      end
    end
  endtask

  initial begin
    fork
      checker_loop();
      begin
        directed();
        random_phase();
        done = 1'b1;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
